// File: rtl/conv_pkg.sv
// Shared types, default geometry and helpers for the convolution operand fetcher.
// Derived word counts are exposed both as defaults and as functions of the geometry.
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_e;

    localparam int DEF_IFM_SIZE    = 9;
    localparam int DEF_PAD         = 2;
    localparam int DEF_KERNEL_SIZE = 4;
    localparam int DEF_CI          = 3;
    localparam int DEF_CO          = 4;

    localparam int N_REAL    = DEF_IFM_SIZE - 2 * DEF_PAD;
    localparam int IFM_WORDS = DEF_CI * N_REAL * N_REAL;
    localparam int WGT_WORDS = DEF_CO * DEF_CI * DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;

    // Ceiling log2, never below 1 so it can size a register.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int calc_ifm_words(input int size, input int pad, input int ci);
        return ci * (size - 2 * pad) * (size - 2 * pad);
    endfunction

    function automatic int calc_wgt_words(input int k, input int ci, input int co);
        return co * ci * k * k;
    endfunction

endpackage

// File: rtl/conv_operand_fetch_stream.sv
// One SRAM read stream: pointer with optional wrap, pass counter,
// exhausted flag, read-enable gating and a 1-cycle valid/data return.
module operand_stream
    import conv_pkg::*;
#(
    parameter int   AW     = 7,
    parameter int   DATA_W = 8,
    parameter int   WORDS  = 75,
    parameter int   PASSES = 4,
    parameter logic WRAP   = 1'b1
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              clear,
    input  logic              enable,
    input  logic              req,
    input  logic [DATA_W-1:0] rdata,
    output logic              ce,
    output logic [AW-1:0]     addr,
    output logic [DATA_W-1:0] data,
    output logic              valid,
    output logic              exhausted,
    output logic              last
);

    localparam int PW = clog2(PASSES + 1);
    localparam logic [AW-1:0] LAST_PTR  = AW'(WORDS - 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(PASSES - 1);

    logic [AW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     pass_q, pass_d;
    logic              exh_q, exh_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              at_end;

    assign ce        = req & enable & ~exh_q;
    assign at_end    = (ptr_q == LAST_PTR);
    assign last      = ce & at_end & (pass_q == LAST_PASS);
    assign addr      = ptr_q;
    assign valid     = valid_q;
    assign exhausted = exh_q;
    // SRAM output is live in the valid cycle; the hold register keeps it afterwards.
    assign data      = valid_q ? rdata : hold_q;

    // Next pointer, pass and exhaustion state for each accepted read.
    always_comb begin
        ptr_d   = ptr_q;
        pass_d  = pass_q;
        exh_d   = exh_q;
        valid_d = ce;
        hold_d  = valid_q ? rdata : hold_q;
        if (clear) begin
            ptr_d  = '0;
            pass_d = '0;
            exh_d  = 1'b0;
        end else if (ce) begin
            if (at_end) begin
                pass_d = pass_q + PW'(1);
                ptr_d  = WRAP ? '0 : ptr_q + AW'(1);
                if (pass_q == LAST_PASS) exh_d = 1'b1;
            end else begin
                ptr_d = ptr_q + AW'(1);
            end
        end
    end

    // Stream state registers.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            ptr_q   <= '0;
            pass_q  <= '0;
            exh_q   <= 1'b0;
            valid_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            ptr_q   <= ptr_d;
            pass_q  <= pass_d;
            exh_q   <= exh_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
        end
    end

endmodule

// File: rtl/conv_operand_fetch.sv
// Operand-request responder: sequences IFM and weight SRAM reads for one
// convolution, returns data with valid flags, flags overruns, pulses done.
module conv_operand_fetch
    import conv_pkg::*;
#(
    parameter int IFM_SIZE    = DEF_IFM_SIZE,
    parameter int PAD         = DEF_PAD,
    parameter int KERNEL_SIZE = DEF_KERNEL_SIZE,
    parameter int CI          = DEF_CI,
    parameter int CO          = DEF_CO,
    parameter int DATA_W      = 8,
    parameter int IFM_AW      = 7,
    parameter int WGT_AW      = 8
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              start_conv,
    input  logic              ifm_read,
    input  logic              wgt_read,
    output logic              ifm_ce,
    output logic [IFM_AW-1:0] ifm_addr,
    input  logic [DATA_W-1:0] ifm_rdata,
    output logic              wgt_ce,
    output logic [WGT_AW-1:0] wgt_addr,
    input  logic [DATA_W-1:0] wgt_rdata,
    output logic [DATA_W-1:0] ifm_data,
    output logic              ifm_valid,
    output logic [DATA_W-1:0] wgt_data,
    output logic              wgt_valid,
    output logic              busy,
    output logic              fetch_done,
    output logic              err_overrun
);

    localparam int IFM_WC = calc_ifm_words(IFM_SIZE, PAD, CI);
    localparam int WGT_WC = calc_wgt_words(KERNEL_SIZE, CI, CO);

    state_e state_q, state_d;
    logic   err_q, err_d;
    logic   active, clear;
    logic   ifm_exh, ifm_last, wgt_exh, wgt_last;
    logic   strobe_err;

    assign active = (state_q == ACTIVE);
    assign clear  = (state_q == IDLE) & start_conv;

    operand_stream #(
        .AW     (IFM_AW),
        .DATA_W (DATA_W),
        .WORDS  (IFM_WC),
        .PASSES (CO),
        .WRAP   (1'b1)
    ) u_ifm (
        .clk1      (clk1),
        .rst       (rst),
        .clear     (clear),
        .enable    (active),
        .req       (ifm_read),
        .rdata     (ifm_rdata),
        .ce        (ifm_ce),
        .addr      (ifm_addr),
        .data      (ifm_data),
        .valid     (ifm_valid),
        .exhausted (ifm_exh),
        .last      (ifm_last)
    );

    operand_stream #(
        .AW     (WGT_AW),
        .DATA_W (DATA_W),
        .WORDS  (WGT_WC),
        .PASSES (1),
        .WRAP   (1'b0)
    ) u_wgt (
        .clk1      (clk1),
        .rst       (rst),
        .clear     (clear),
        .enable    (active),
        .req       (wgt_read),
        .rdata     (wgt_rdata),
        .ce        (wgt_ce),
        .addr      (wgt_addr),
        .data      (wgt_data),
        .valid     (wgt_valid),
        .exhausted (wgt_exh),
        .last      (wgt_last)
    );

    // A strobe that cannot be served is a protocol overrun.
    assign strobe_err = (ifm_read & ~(active & ~ifm_exh))
                      | (wgt_read & ~(active & ~wgt_exh));

    // Next state and sticky error; a new start clears the flag.
    always_comb begin
        state_d = state_q;
        err_d   = clear ? strobe_err : (err_q | strobe_err);
        unique case (state_q)
            IDLE:   if (start_conv) state_d = ACTIVE;
            ACTIVE: if ((ifm_exh | ifm_last) & (wgt_exh | wgt_last))
                        state_d = DRAIN;
            DRAIN:  state_d = DONE;
            DONE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and error registers.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign busy        = (state_q == ACTIVE) | (state_q == DRAIN);
    assign fetch_done  = (state_q == DONE);
    assign err_overrun = err_q;

endmodule

// File: tb/tb_conv_operand_fetch.sv
// Directed/random bench for conv_operand_fetch with a transaction-count model.
// SRAMs are modelled as 1-cycle registered lookups of simple address functions.
module tb_conv_operand_fetch;

    localparam int IFM_WORDS = 3 * 5 * 5;
    localparam int IFM_TOT   = 4 * IFM_WORDS;
    localparam int WGT_TOT   = 4 * 3 * 4 * 4;

    logic       clk1 = 1'b0;
    logic       rst = 1'b1;
    logic       start_conv = 1'b0;
    logic       ifm_read = 1'b0;
    logic       wgt_read = 1'b0;
    logic       ifm_ce, wgt_ce;
    logic [6:0] ifm_addr;
    logic [7:0] wgt_addr;
    logic [7:0] ifm_rdata = 8'h00;
    logic [7:0] wgt_rdata = 8'h00;
    logic [7:0] ifm_data, wgt_data;
    logic       ifm_valid, wgt_valid;
    logic       busy, fetch_done, err_overrun;

    int checks = 0;
    int errors = 0;

    int   n_ifm = 0;
    int   n_wgt = 0;
    bit   running = 0;
    int   post = 0;
    bit   e_err = 0;
    bit   e_ivalid = 0;
    bit   e_wvalid = 0;
    logic [7:0] e_idata = 8'h00;
    logic [7:0] e_wdata = 8'h00;
    int   done_seen = 0;

    conv_operand_fetch dut (
        .clk1        (clk1),
        .rst         (rst),
        .start_conv  (start_conv),
        .ifm_read    (ifm_read),
        .wgt_read    (wgt_read),
        .ifm_ce      (ifm_ce),
        .ifm_addr    (ifm_addr),
        .ifm_rdata   (ifm_rdata),
        .wgt_ce      (wgt_ce),
        .wgt_addr    (wgt_addr),
        .wgt_rdata   (wgt_rdata),
        .ifm_data    (ifm_data),
        .ifm_valid   (ifm_valid),
        .wgt_data    (wgt_data),
        .wgt_valid   (wgt_valid),
        .busy        (busy),
        .fetch_done  (fetch_done),
        .err_overrun (err_overrun)
    );

    always #5 clk1 = ~clk1;

    function automatic logic [7:0] ifm_word(input int a);
        return a[7:0];
    endfunction

    function automatic logic [7:0] wgt_word(input int a);
        int t;
        t = a * 7 + 3;
        return t[7:0];
    endfunction

    always @(posedge clk1) begin
        if (ifm_ce) ifm_rdata <= ifm_word(int'(ifm_addr));
        if (wgt_ce) wgt_rdata <= wgt_word(int'(wgt_addr));
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive strobes, check against the model, advance it.
    task automatic step(input bit ir, input bit wr, input bit st);
        bit ice, wce, idle, ev;
        ifm_read   = ir;
        wgt_read   = wr;
        start_conv = st;
        idle = !running && post == 0;
        ice  = ir && running && n_ifm < IFM_TOT;
        wce  = wr && running && n_wgt < WGT_TOT;
        @(negedge clk1);
        chk("ifm_ce", ifm_ce, ice);
        chk("wgt_ce", wgt_ce, wce);
        chk("ifm_addr", ifm_addr, n_ifm % IFM_WORDS);
        chk("wgt_addr", wgt_addr, n_wgt % 256);
        chk("ifm_valid", ifm_valid, e_ivalid);
        chk("ifm_data", ifm_data, e_idata);
        chk("wgt_valid", wgt_valid, e_wvalid);
        chk("wgt_data", wgt_data, e_wdata);
        chk("busy", busy, running || post == 2);
        chk("fetch_done", fetch_done, post == 1);
        chk("err_overrun", err_overrun, e_err);
        if (fetch_done === 1'b1) done_seen++;
        ev = (ir && !ice) || (wr && !wce);
        e_ivalid = ice;
        e_wvalid = wce;
        if (ice) e_idata = ifm_word(n_ifm % IFM_WORDS);
        if (wce) e_wdata = wgt_word(n_wgt);
        if (ice) n_ifm++;
        if (wce) n_wgt++;
        if (post > 0) post--;
        if (running && n_ifm == IFM_TOT && n_wgt == WGT_TOT) begin
            running = 0;
            post    = 2;
        end
        if (idle && st) begin
            running = 1;
            n_ifm   = 0;
            n_wgt   = 0;
            e_err   = ev;
        end else begin
            e_err = e_err | ev;
        end
        @(posedge clk1);
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle with a strobe pending.
    task automatic mid_reset(input bit ir);
        ifm_read   = ir;
        wgt_read   = 1'b0;
        start_conv = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("rst_ifm_ce", ifm_ce, 0);
        chk("rst_wgt_ce", wgt_ce, 0);
        chk("rst_ifm_addr", ifm_addr, 0);
        chk("rst_wgt_addr", wgt_addr, 0);
        chk("rst_ifm_data", ifm_data, 0);
        chk("rst_ifm_valid", ifm_valid, 0);
        chk("rst_wgt_data", wgt_data, 0);
        chk("rst_wgt_valid", wgt_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fetch_done", fetch_done, 0);
        chk("rst_err", err_overrun, 0);
        ifm_read = 1'b0;
        n_ifm = 0; n_wgt = 0; running = 0; post = 0; e_err = 0;
        e_ivalid = 0; e_wvalid = 0; e_idata = 8'h00; e_wdata = 8'h00;
        @(posedge clk1);
        #1;
        @(posedge clk1);
        #2 rst = 1'b0;
        @(posedge clk1);
        #1;
    endtask

    initial begin
        bit ir, wr, ovr;
        repeat (2) @(posedge clk1);
        #1 rst = 1'b0;

        step(0, 0, 0);
        step(0, 0, 0);

        // Weight strobe while idle, then a clearing start.
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 1);

        // Run 1: back-to-back IFM, simultaneous strobes, random tail.
        for (int i = 0; i < 75; i++) step(1, 0, 0);
        for (int i = 0; i < 48; i++) step(1, 1, 0);
        ovr = 0;
        for (int c = 0; c < 3000 && running; c++) begin
            ir = (n_ifm < IFM_TOT) && ($urandom_range(0, 1) == 1);
            wr = (n_ifm == IFM_TOT || n_wgt < WGT_TOT - 8)
                 && ($urandom_range(0, 3) == 0);
            if (n_ifm == IFM_TOT && !ovr) begin
                step(1, 0, 0);
                ovr = 1;
            end else begin
                step(ir, wr, 0);
            end
        end
        chk("run1_complete", running, 0);
        repeat (3) step(0, 0, 0);
        chk("run1_done_count", done_seen, 1);

        // Run 2: aborted by reset during IFM strobe 100.
        step(0, 0, 1);
        for (int c = 0; c < 500 && n_ifm < 99; c++)
            step(1, $urandom_range(0, 1) == 1, 0);
        chk("run2_reached_99", n_ifm, 99);
        mid_reset(1);
        step(0, 0, 0);
        step(0, 0, 0);

        // Run 3: fully random strobes to completion.
        step(0, 0, 1);
        for (int c = 0; c < 4000 && running; c++)
            step($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, 0);
        chk("run3_complete", running, 0);
        repeat (3) step(0, 0, 0);
        chk("run3_done_count", done_seen, 2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/conv_operand_fetch.md
Name: conv_operand_fetch

Overview:
- Responder on the convolution controller's operand-request interface.
- Turns the controller's per-cycle ifm_read and wgt_read strobes into sequential reads of the IFM SRAM and the weight SRAM, both of which have a 1-cycle read latency.
- Returns registered data with valid flags to the PE datapath.
- Tracks filter passes, flags protocol overruns and pulses fetch_done when the whole convolution's operands have been delivered.

Parameters:
- IFM_SIZE, 9: padded feature-map edge as counted by the controller.
- PAD, 2: padding on each side. Real edge N = IFM_SIZE-2*PAD.
- KERNEL_SIZE, 4: kernel edge.
- CI, 3: input channels.
- CO, 4: output filters, i.e. the number of full IFM re-read passes.
- DATA_W, 8: operand width.
- IFM_AW, 7: IFM address width. Must satisfy 2^IFM_AW >= CI*N*N.
- WGT_AW, 8: weight address width. Must satisfy 2^WGT_AW >= CO*CI*KERNEL_SIZE^2.

Ports:
- clk1 in 1: single clock.
- rst in 1: asynchronous, active-high reset.
- start_conv in 1: begin a convolution. Sampled only in IDLE.
- ifm_read in 1: controller requests the next non-pad IFM pixel this cycle.
- wgt_read in 1: controller requests the next weight this cycle.
- ifm_ce out 1: IFM SRAM read enable.
- ifm_addr out IFM_AW: IFM SRAM address.
- ifm_rdata in DATA_W: IFM SRAM data, valid 1 cycle after ifm_ce.
- wgt_ce out 1: weight SRAM read enable.
- wgt_addr out WGT_AW: weight SRAM address.
- wgt_rdata in DATA_W: weight SRAM data, valid 1 cycle after wgt_ce.
- ifm_data out DATA_W: pixel to the datapath.
- ifm_valid out 1: ifm_data is new this cycle.
- wgt_data out DATA_W: weight to the datapath.
- wgt_valid out 1: wgt_data is new this cycle.
- busy out 1: high in ACTIVE and DRAIN.
- fetch_done out 1: 1-cycle pulse on completion.
- err_overrun out 1: sticky protocol-error flag.

Behaviour:
- Reset: all outputs 0, all counters 0, state IDLE.
- Reset mid-operation aborts immediately. No pulse of fetch_done.
- States:
  - IDLE: on start_conv go to ACTIVE. All counters and err_overrun clear on that cycle's edge.
  - ACTIVE: serves reads. When the last IFM read (pass CO-1, addr CI*N*N-1) and the last weight read (addr CO*CI*K^2-1) have both been accepted, go to DRAIN. The two may complete in different cycles.
  - DRAIN: 1 cycle, waits for the final SRAM data. Then go to DONE.
  - DONE: fetch_done=1 for 1 cycle, then go to IDLE.
- start_conv outside IDLE is ignored.
- IFM path:
  - ifm_ce = ifm_read & (state==ACTIVE) & IFM not exhausted. Combinational.
  - ifm_addr = ifm_ptr (registered).
  - On an accepted read: ifm_ptr+1. At CI*N*N-1 it wraps to 0 and pass_cnt+1.
  - pass_cnt reaching CO marks IFM exhausted.
  - Address order is channel-major then raster: ch*N*N + row*N + col.
- Weight path:
  - wgt_ce = wgt_read & (state==ACTIVE) & weights not exhausted.
  - wgt_ptr increments per accepted read, with no wrap. Reaching CO*CI*K^2 marks weights exhausted.
- Data return:
  - ifm_valid and wgt_valid are ifm_ce and wgt_ce delayed 1 cycle.
  - ifm_data and wgt_data register the rdata when the matching valid rises, and hold their last value otherwise.
  - Total latency from strobe to data is 1 cycle. Back-to-back strobes every cycle are supported, giving full throughput.
- Simultaneous ifm_read and wgt_read are served independently in the same cycle.
- err_overrun sets and holds until the next accepted start when either of these occurs:
  - ifm_read or wgt_read is asserted in IDLE, DRAIN or DONE;
  - a strobe arrives after its stream is exhausted.
- Strobes that set err_overrun cause no SRAM access and no pointer change.
- Counter arithmetic is unsigned. Compare against parameter-derived constants sized to the counter width.

Decomposition:
- Shared package conv_pkg:
  - state enum (IDLE, ACTIVE, DRAIN, DONE);
  - derived localparams N_REAL = IFM_SIZE-2*PAD, IFM_WORDS = CI*N_REAL^2, WGT_WORDS = CO*CI*KERNEL_SIZE^2;
  - a clog2 function.
- One sub-module, operand_stream, is instantiated twice (IFM and weight). It contains:
  - pointer with optional wrap;
  - pass counter;
  - exhausted flag;
  - ce gating;
  - 1-cycle valid/data register.
- The top level holds the FSM and error logic.

Test Plan:
- Defaults (N=5): start_conv, then 300 single-cycle ifm_read strobes and 192 wgt_read strobes.
  - ifm_addr sequence is 0..74 repeated 4 times.
  - wgt_addr runs 0..191.
  - fetch_done pulses exactly 2 cycles after the later of the two final strobes.
- Latency check: ifm_rdata mirrors the address.
  - ifm_data equals the previous cycle's ifm_addr whenever ifm_valid=1.
  - Back-to-back strobes for 75 cycles give 75 consecutive ifm_valid pulses.
- Simultaneous strobes: ifm_read and wgt_read held high together for 48 cycles.
  - Both ce signals are high every cycle.
  - Both valid signals are high with data matching the two SRAM models.
- Overrun: a 301st ifm_read strobe.
  - ifm_ce stays 0 and err_overrun=1.
  - fetch_done still pulses once.
  - A following start_conv clears err_overrun.
- Idle strobe: wgt_read asserted before start_conv.
  - wgt_ce=0 and err_overrun=1.
  - After start, wgt_addr begins at 0.
- Reset at IFM strobe 100:
  - all outputs 0 asynchronously and no fetch_done;
  - after release and a new start, ifm_addr restarts at 0 with pass 0.
